uart_cmd_rx: RTL and testbench

Parametrised UART receiver with an integrated drive-command decoder and a command-loss watchdog.
- Receives frames from the Bluetooth/serial link and decodes an ASCII digit range into a drive command for the motor controller.
- Reverts to command 0 (stop) if the link goes silent.
- Width, parity, stop bits, baud divisor and command count are all configurable.

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 52 +++++
 rtl/uart_cmd_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command receiver.
//   rx_state_e  : receiver state encoding
//   PARITY_*    : parity mode selectors for PARITY_MODE
//   parity_bit  : expected parity bit for a zero-extended data word
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CLEANUP,
        BREAK
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Zero extension of the data word does not change its XOR reduction.
    function automatic logic parity_bit(input logic [15:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line synchroniser with optional majority-vote bit sampler.
// Optional feature macro: UART_CMD_RX_MAJORITY_EN.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   rx_async in   raw serial line, idle high
//   rx_line  out  2-flop synchronised line (used for edge/idle detection)
//   rx_bit   out  bit value to use at a centre sample
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_line,
    output logic rx_bit
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_async;
            sync_q <= meta_q;
        end
    end

    assign rx_line = sync_q;

`ifdef UART_CMD_RX_MAJORITY_EN
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sync_q;
        end
    end

    // The first stage runs one cycle ahead of rx_line, so it supplies the
    // centre+1 tap and the vote resolves on the centre count itself; output
    // timing therefore matches the single-sample build. A marginal value in
    // that stage can only sway one of the three votes.
    assign rx_bit = (prev_q & sync_q) | (prev_q & meta_q) | (sync_q & meta_q);
`else
    assign rx_bit = sync_q;
`endif

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receiver with drive-command decoder and command-loss watchdog.
// Optional feature macro: UART_CMD_RX_MAJORITY_EN (2-of-3 bit voting).
// Ports:
//   i_Clock      in   system clock
//   i_Reset_n    in   asynchronous active-low reset
//   i_Rx_Serial  in   serial line, idle high
//   o_Rx_DV      out  pulse: o_Rx_Byte valid
//   o_Rx_Byte    out  last good received word
//   o_Frame_Err  out  pulse: stop bit sampled low
//   o_Parity_Err out  pulse: parity mismatch
//   o_Cmd        out  current drive command (held)
//   o_Cmd_Stb    out  pulse: valid command accepted
//   o_Timeout    out  level: watchdog expired
module uart_cmd_rx import uart_cmd_pkg::*; #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CMD_BASE     = 48,
    parameter int NUM_CMDS     = 3,
    parameter int TIMEOUT_CLKS = 0,
    localparam int CMD_W       = (NUM_CMDS > 2) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic [CMD_W-1:0]     o_Cmd,
    output logic                 o_Cmd_Stb,
    output logic                 o_Timeout
);

    localparam int CTR_W = $clog2(CLKS_PER_BIT);
    localparam logic [CTR_W-1:0] CENTER    = CTR_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CTR_W-1:0] LAST_CNT  = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    logic rx_line;
    logic rx_bit;

    uart_rx_sync u_sync (
        .clk      (i_Clock),
        .rst_n    (i_Reset_n),
        .rx_async (i_Rx_Serial),
        .rx_line  (rx_line),
        .rx_bit   (rx_bit)
    );

    rx_state_e            state_q, state_d;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic                 cmd_stb_q, cmd_stb_d;

    logic             at_center;
    logic             at_end;
    logic [CTR_W-1:0] ctr_bump;
    logic             rx_dv;
    logic             frame_err;
    logic             parity_err;
    logic             cmd_hit;
    logic [CMD_W-1:0] cmd_val;
    logic [31:0]      byte_ext;
    logic             expire;

    assign at_center = (ctr_q == CENTER);
    assign at_end    = (ctr_q == LAST_CNT);
    assign ctr_bump  = at_end ? '0 : ctr_q + 1'b1;

    // State register and datapath flops
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= IDLE;
            ctr_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            byte_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            cmd_q     <= '0;
            cmd_stb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            byte_q    <= byte_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            cmd_q     <= cmd_d;
            cmd_stb_q <= cmd_stb_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        byte_d  = byte_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            IDLE: begin
                ctr_d  = '0;
                idx_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (!rx_line) state_d = START;
            end
            START: begin
                ctr_d = ctr_bump;
                if (at_center && rx_bit) state_d = IDLE;
                else if (at_end)         state_d = DATA;
            end
            DATA: begin
                ctr_d = ctr_bump;
                if (at_center) data_d = {rx_bit, data_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                ctr_d = ctr_bump;
                if (at_center) perr_d = (rx_bit != parity_bit(16'(data_q), PARITY_MODE));
                if (at_end)    state_d = STOP;
            end
            STOP: begin
                ctr_d = ctr_bump;
                if (at_center) begin
                    if (!rx_bit) ferr_d = 1'b1;
                    // Leave at the centre of the last stop bit so the outcome
                    // pulse lands half a bit before the frame ends.
                    if (idx_q == LAST_STOP) begin
                        state_d = CLEANUP;
                        ctr_d   = '0;
                        idx_d   = '0;
                        if (rx_bit && !ferr_q && !perr_q) byte_d = data_q;
                    end
                end else if (at_end) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CLEANUP: begin
                state_d = ferr_q ? BREAK : IDLE;
            end
            BREAK: begin
                if (rx_line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outcome pulses
    always_comb begin
        rx_dv      = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        if (state_q == CLEANUP) begin
            if (ferr_q)      frame_err  = 1'b1;
            else if (perr_q) parity_err = 1'b1;
            else             rx_dv      = 1'b1;
        end
    end

    // Command decode; byte_q is below 2**DATA_BITS, so out-of-width command
    // codes can never match.
    assign byte_ext = 32'(byte_q);
    assign cmd_hit  = rx_dv && (byte_ext >= 32'(CMD_BASE))
                            && (byte_ext <  32'(CMD_BASE + NUM_CMDS));
    assign cmd_val  = CMD_W'(byte_ext - 32'(CMD_BASE));

    always_comb begin
        cmd_d     = cmd_q;
        cmd_stb_d = cmd_hit;
        if (expire)  cmd_d = '0;
        if (cmd_hit) cmd_d = cmd_val;
    end

    generate
        if (TIMEOUT_CLKS > 0) begin : g_wd
            localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
            localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CLKS);

            logic [WD_W-1:0] wd_q, wd_d;
            logic            to_q, to_d;

            always_ff @(posedge i_Clock or negedge i_Reset_n) begin
                if (!i_Reset_n) begin
                    wd_q <= '0;
                    to_q <= 1'b0;
                end else begin
                    wd_q <= wd_d;
                    to_q <= to_d;
                end
            end

            // Expiry fires once, on the edge where the count reaches the limit.
            always_comb begin
                wd_d   = wd_q;
                to_d   = to_q;
                expire = 1'b0;
                if (cmd_hit) begin
                    wd_d = '0;
                    to_d = 1'b0;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_MAX) begin
                        expire = 1'b1;
                        to_d   = 1'b1;
                    end
                end
            end

            assign o_Timeout = to_q;
        end else begin : g_no_wd
            assign expire    = 1'b0;
            assign o_Timeout = 1'b0;
        end
    endgenerate

    assign o_Rx_DV      = rx_dv;
    assign o_Rx_Byte    = byte_q;
    assign o_Frame_Err  = frame_err;
    assign o_Parity_Err = parity_err;
    assign o_Cmd        = cmd_q;
    assign o_Cmd_Stb    = cmd_stb_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

    localparam int CPB = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0   = 1'b1;
    logic       rx1   = 1'b1;

    logic       dv0, fe0, pe0, stb0, to0;
    logic [7:0] byte0;
    logic [1:0] cmd0;
    logic       dv1, fe1, pe1, stb1, to1;
    logic [7:0] byte1;
    logic [1:0] cmd1;

    int errors = 0;
    int checks = 0;

    int dv0_n = 0, fe0_n = 0, pe0_n = 0, stb0_n = 0;
    int dv1_n = 0, fe1_n = 0, pe1_n = 0;

    // 8N1 with a 1000-clock watchdog
    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_MODE  (0),
        .STOP_BITS    (1),
        .CMD_BASE     (48),
        .NUM_CMDS     (3),
        .TIMEOUT_CLKS (1000)
    ) dut0 (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Rx_Serial  (rx0),
        .o_Rx_DV      (dv0),
        .o_Rx_Byte    (byte0),
        .o_Frame_Err  (fe0),
        .o_Parity_Err (pe0),
        .o_Cmd        (cmd0),
        .o_Cmd_Stb    (stb0),
        .o_Timeout    (to0)
    );

    // 8E2, no watchdog
    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_MODE  (2),
        .STOP_BITS    (2),
        .CMD_BASE     (48),
        .NUM_CMDS     (3),
        .TIMEOUT_CLKS (0)
    ) dut1 (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Rx_Serial  (rx1),
        .o_Rx_DV      (dv1),
        .o_Rx_Byte    (byte1),
        .o_Frame_Err  (fe1),
        .o_Parity_Err (pe1),
        .o_Cmd        (cmd1),
        .o_Cmd_Stb    (stb1),
        .o_Timeout    (to1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dv0  === 1'b1) dv0_n  <= dv0_n + 1;
        if (fe0  === 1'b1) fe0_n  <= fe0_n + 1;
        if (pe0  === 1'b1) pe0_n  <= pe0_n + 1;
        if (stb0 === 1'b1) stb0_n <= stb0_n + 1;
        if (dv1  === 1'b1) dv1_n  <= dv1_n + 1;
        if (fe1  === 1'b1) fe1_n  <= fe1_n + 1;
        if (pe1  === 1'b1) pe1_n  <= pe1_n + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // Drive bits[0..n-1], one bit period each, starting on a falling edge.
    task automatic send_raw(input int which, input logic [11:0] bits, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx0 = bits[i];
            else            rx1 = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Wait (bounded) for an o_Rx_DV pulse; returns at the falling edge it is seen.
    task automatic wait_dv(input int which, output bit got);
        got = 1'b0;
        for (int i = 0; i < 3 * CPB && !got; i++) begin
            @(negedge clk);
            if (which == 0 && dv0 === 1'b1) got = 1'b1;
            if (which == 1 && dv1 === 1'b1) got = 1'b1;
        end
    endtask

    task automatic send8n1(input logic [7:0] data, input logic stop);
        send_raw(0, 12'({data, 1'b0}), 9);
        rx0 = stop;
    endtask

    task automatic send8e2(input logic [7:0] data, input logic par);
        send_raw(1, 12'({1'b1, par, data, 1'b0}), 11);
        rx1 = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dv0, fe0, pe0, stb0, to0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses0: got %b expected 00000", {dv0, fe0, pe0, stb0, to0});
        end
        checks++;
        if ({cmd0, byte0} !== 10'h0) begin
            errors++;
            $display("FAIL reset_data0: cmd=%0d byte=%h expected 0/00", cmd0, byte0);
        end
        checks++;
        if ({dv1, fe1, pe1, stb1, to1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses1: got %b expected 00000", {dv1, fe1, pe1, stb1, to1});
        end
        checks++;
        if ({cmd1, byte1} !== 10'h0) begin
            errors++;
            $display("FAIL reset_data1: cmd=%0d byte=%h expected 0/00", cmd1, byte1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd_valid;
        bit got;
        send8n1(8'h31, 1'b1);
        wait_dv(0, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cmd1_dv: no o_Rx_DV pulse seen, expected one");
        end else begin
            checks++;
            if (byte0 !== 8'h31) begin
                errors++;
                $display("FAIL cmd1_byte: got %h expected 31", byte0);
            end
            checks++;
            if (stb0 !== 1'b0) begin
                errors++;
                $display("FAIL cmd1_stb_early: got %b expected 0", stb0);
            end
            @(negedge clk);
            checks++;
            if (cmd0 !== 2'd1 || stb0 !== 1'b1 || dv0 !== 1'b0) begin
                errors++;
                $display("FAIL cmd1_decode: cmd=%0d stb=%b dv=%b expected 1/1/0", cmd0, stb0, dv0);
            end
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_non_cmd;
        bit got;
        int stb_snap;
        send8n1(8'h32, 1'b1);
        wait_dv(0, got);
        @(negedge clk);
        checks++;
        if (!got || cmd0 !== 2'd2 || stb0 !== 1'b1) begin
            errors++;
            $display("FAIL cmd2_decode: seen=%0d cmd=%0d stb=%b expected 1/2/1", got, cmd0, stb0);
        end
        repeat (CPB) @(negedge clk);
        #1;
        stb_snap = stb0_n;
        send8n1(8'h41, 1'b1);
        wait_dv(0, got);
        checks++;
        if (!got || byte0 !== 8'h41) begin
            errors++;
            $display("FAIL nocmd_byte: seen=%0d byte=%h expected 1/41", got, byte0);
        end
        @(negedge clk);
        checks++;
        if (cmd0 !== 2'd2 || stb0 !== 1'b0) begin
            errors++;
            $display("FAIL nocmd_hold: cmd=%0d stb=%b expected 2/0", cmd0, stb0);
        end
        repeat (CPB) @(negedge clk);
        #1;
        checks++;
        if (stb0_n !== stb_snap) begin
            errors++;
            $display("FAIL nocmd_stb_count: got %0d expected %0d", stb0_n, stb_snap);
        end
    endtask

    task automatic test_parity;
        bit got;
        int dv_snap, pe_snap;
        // 0x32 has three set bits: even parity bit is 1
        send8e2(8'h32, 1'b1);
        wait_dv(1, got);
        checks++;
        if (!got || byte1 !== 8'h32) begin
            errors++;
            $display("FAIL par_good_byte: seen=%0d byte=%h expected 1/32", got, byte1);
        end
        @(negedge clk);
        checks++;
        if (cmd1 !== 2'd2 || stb1 !== 1'b1 || to1 !== 1'b0) begin
            errors++;
            $display("FAIL par_good_cmd: cmd=%0d stb=%b to=%b expected 2/1/0", cmd1, stb1, to1);
        end
        repeat (CPB) @(negedge clk);
        #1;
        dv_snap = dv1_n;
        pe_snap = pe1_n;
        // 0x30 has two set bits: even parity bit should be 0, send 1
        send8e2(8'h30, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 3 * CPB && !got; i++) begin
            @(negedge clk);
            if (pe1 === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || dv1 !== 1'b0 || fe1 !== 1'b0) begin
            errors++;
            $display("FAIL par_bad_pulse: perr_seen=%0d dv=%b ferr=%b expected 1/0/0", got, dv1, fe1);
        end
        @(negedge clk);
        checks++;
        if (cmd1 !== 2'd2 || stb1 !== 1'b0) begin
            errors++;
            $display("FAIL par_bad_cmd: cmd=%0d stb=%b expected 2/0", cmd1, stb1);
        end
        repeat (CPB) @(negedge clk);
        #1;
        checks++;
        if (dv1_n !== dv_snap || pe1_n !== pe_snap + 1) begin
            errors++;
            $display("FAIL par_bad_counts: dv=%0d perr=%0d expected %0d/%0d", dv1_n, pe1_n, dv_snap, pe_snap + 1);
        end
    endtask

    task automatic test_glitch;
        bit got;
        int dv_snap, fe_snap, pe_snap;
        #1;
        dv_snap = dv0_n;
        fe_snap = fe0_n;
        pe_snap = pe0_n;
        @(negedge clk);
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        #1;
        checks++;
        if (dv0_n !== dv_snap || fe0_n !== fe_snap || pe0_n !== pe_snap) begin
            errors++;
            $display("FAIL glitch_pulses: dv=%0d ferr=%0d perr=%0d expected %0d/%0d/%0d",
                     dv0_n, fe0_n, pe0_n, dv_snap, fe_snap, pe_snap);
        end
        send8n1(8'h30, 1'b1);
        wait_dv(0, got);
        checks++;
        if (!got || byte0 !== 8'h30) begin
            errors++;
            $display("FAIL glitch_recover: seen=%0d byte=%h expected 1/30", got, byte0);
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_frame_err;
        bit got;
        int dv_snap, fe_snap, pe_snap;
        #1;
        dv_snap = dv0_n;
        fe_snap = fe0_n;
        pe_snap = pe0_n;
        send8n1(8'h33, 1'b0);
        // Hold the line low well beyond a full frame time.
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (fe0_n !== fe_snap + 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d expected %0d", fe0_n, fe_snap + 1);
        end
        checks++;
        if (dv0_n !== dv_snap || pe0_n !== pe_snap) begin
            errors++;
            $display("FAIL ferr_other: dv=%0d perr=%0d expected %0d/%0d", dv0_n, pe0_n, dv_snap, pe_snap);
        end
        rx0 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send8n1(8'h31, 1'b1);
        wait_dv(0, got);
        checks++;
        if (!got || byte0 !== 8'h31) begin
            errors++;
            $display("FAIL ferr_recover: seen=%0d byte=%h expected 1/31", got, byte0);
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit got;
        int stb_snap;
        send8n1(8'h32, 1'b1);
        wait_dv(0, got);
        @(negedge clk);
        checks++;
        if (!got || stb0 !== 1'b1 || cmd0 !== 2'd2 || to0 !== 1'b0) begin
            errors++;
            $display("FAIL wd_arm: seen=%0d stb=%b cmd=%0d to=%b expected 1/1/2/0", got, stb0, cmd0, to0);
        end
        #1;
        stb_snap = stb0_n;
        repeat (999) @(negedge clk);
        checks++;
        if (cmd0 !== 2'd2 || to0 !== 1'b0) begin
            errors++;
            $display("FAIL wd_before: cmd=%0d to=%b expected 2/0", cmd0, to0);
        end
        @(negedge clk);
        checks++;
        if (cmd0 !== 2'd0 || to0 !== 1'b1 || stb0 !== 1'b0) begin
            errors++;
            $display("FAIL wd_expire: cmd=%0d to=%b stb=%b expected 0/1/0", cmd0, to0, stb0);
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (to0 !== 1'b1 || stb0_n !== stb_snap) begin
            errors++;
            $display("FAIL wd_hold: to=%b stb_count=%0d expected 1/%0d", to0, stb0_n, stb_snap);
        end
        send8n1(8'h31, 1'b1);
        wait_dv(0, got);
        @(negedge clk);
        checks++;
        if (!got || cmd0 !== 2'd1 || stb0 !== 1'b1 || to0 !== 1'b0) begin
            errors++;
            $display("FAIL wd_clear: seen=%0d cmd=%0d stb=%b to=%b expected 1/1/1/0", got, cmd0, stb0, to0);
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit got;
        // Start bit plus two data bits of 0x31, then reset inside data bit 2.
        send_raw(0, 12'b0000_0000_0010, 3);
        rx0 = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dv0, fe0, pe0, stb0, to0, cmd0, byte0} !== 15'h0) begin
            errors++;
            $display("FAIL rstmid_out0: dv=%b fe=%b pe=%b stb=%b to=%b cmd=%0d byte=%h expected all 0",
                     dv0, fe0, pe0, stb0, to0, cmd0, byte0);
        end
        checks++;
        if ({cmd1, byte1} !== 10'h0) begin
            errors++;
            $display("FAIL rstmid_out1: cmd=%0d byte=%h expected 0/00", cmd1, byte1);
        end
        rx0 = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send8n1(8'h30, 1'b1);
        wait_dv(0, got);
        checks++;
        if (!got || byte0 !== 8'h30) begin
            errors++;
            $display("FAIL rstmid_frame: seen=%0d byte=%h expected 1/30", got, byte0);
        end
        @(negedge clk);
        checks++;
        if (stb0 !== 1'b1 || cmd0 !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_cmd: stb=%b cmd=%0d expected 1/0", stb0, cmd0);
        end
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cmd_valid();
        test_non_cmd();
        test_parity();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
